// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
//   Shares one APB master port between NREQ internal requesters. A requester
//   is picked round-robin while the bus is idle, and the block then runs the
//   APB SETUP and ACCESS phases itself. Wait states are honoured, read data
//   and a completion pulse go back to the granted requester, and a transfer
//   stalled for TIMEOUT ACCESS cycles is aborted with rsp_err.
//
// Ports
//   pclk, presetn     clock, asynchronous active-low reset
//   req_valid[i]      requester i wants a transfer (held until req_ready[i])
//   req_write[i]      1 = write, 0 = read
//   req_addr          4 bits per requester, requester i at [4i+3:4i]
//   req_wdata         8 bits per requester, requester i at [8i+7:8i]
//   req_ready         one-hot accept strobe (combinational, IDLE only)
//   rsp_valid         one-hot completion pulse (registered)
//   rsp_rdata         read data, valid with rsp_valid
//   rsp_err           timeout abort, valid with rsp_valid
//   paddr..pwdata     registered APB master outputs
//   prdata, pready    APB slave returns
//
// Parameters
//   NREQ      number of requesters, 2..8
//   TIMEOUT   ACCESS cycles with pready low before abort, 0 = never abort
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | bus free; arbitrate and accept one request
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1 until pready or timeout
// ---------------------------------------------------------------------------
module apb_rr_master #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_write,
    input  logic [4*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_err,
    output logic [3:0]          paddr,
    output logic                pwrite,
    output logic                psel,
    output logic                penable,
    output logic [7:0]          pwdata,
    input  logic [7:0]          prdata,
    input  logic                pready
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;       // last granted requester; also owns the current transfer
    logic [PW-1:0]   gnt_idx;
    logic            any_req;
    logic [CW-1:0]   cnt;
    logic            timeout_hit;
    logic            done;

    assign any_req = |req_valid;

    // Round-robin search starting at ptr+1. Walking k from the far end
    // downwards lets the nearest set bit win without an early exit.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                gnt_idx = PW'(idx);
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && !pready && (cnt == TO_LAST);
    assign done        = (state == ACCESS) && (pready || timeout_hit);

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic (combinational accept strobe)
    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && any_req) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Registered APB outputs, response and timeout counter
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ptr       <= PW'(NREQ - 1);
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        ptr     <= gnt_idx;
                        paddr   <= req_addr[4*int'(gnt_idx) +: 4];
                        pwrite  <= req_write[gnt_idx];
                        pwdata  <= req_write[gnt_idx] ? req_wdata[8*int'(gnt_idx) +: 8] : 8'h00;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (done) begin
                        psel           <= 1'b0;
                        penable        <= 1'b0;
                        cnt            <= '0;
                        rsp_valid[ptr] <= 1'b1;
                        if (pready) begin
                            if (!pwrite) begin
                                rsp_rdata <= prdata;
                            end
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 8'h00;
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule
